instruction_fetch_unit: RTL and testbench
=========================================

# instruction_fetch_unit

Front-end fetch/decode stage of the datapath, the consumer side of the program ROM interface. Drives the 16-bit instruction address to the combinational ROM, registers the returned 28-bit instruction, and splits it into opcode, destination and source fields. Delivers one instruction per cycle to the execute stage over a valid/ready handshake, stalls on back-pressure (e.g. multi-cycle IMUL), and redirects on a taken branch with a one-cycle bubble.

## Interface
- RESET_PC, 16'd0, first address fetched after reset.
- OP_WIDTH, 4, opcode field width; the opcode is instruction bits [27:24].
- REG_WIDTH, 8, register/operand field width; instruction = {op, dest, src1, src0}.
- Clock  input  1  system clock, all state updates on rising edge.
- Reset  input  1  asynchronous, active-high; one clock, reset is asynchronous and active-high.
- oAddress  output  16  ROM address, equals internal PC combinationally.
- iInstruction  input  28  ROM data for oAddress, valid in the same cycle.
- iEnable  input  1  1 = fetch allowed; 0 = no new fetches.
- iBranchTaken  input  1  redirect request from execute, single-cycle pulse.
- iBranchTarget  input  16  new PC, sampled when iBranchTaken=1.
- oValid  output  1  output fields hold a valid instruction.
- iReady  input  1  execute stage accepts the instruction this cycle.
- oOpcode  output  4  instruction [27:24].
- oDest  output  8  instruction [23:16].
- oSrc1  output  8  instruction [15:8].
- oSrc0  output  8  instruction [7:0].
- oImm  output  16  instruction [15:0] (STO immediate, NOP/LED payload low bits).
- oPC  output  16  address the presented instruction was fetched from.
- oFetchCount  output  16  instructions accepted (oValid&&iReady) since reset, wraps.

## Operation
- State: PC (16b), output register {oValid, fields, oPC}, oFetchCount.
- Reset: PC=RESET_PC, oValid=0, oOpcode/oDest/oSrc1/oSrc0/oImm=0, oPC=0, oFetchCount=0.
- Accept = oValid && iReady. Load = iEnable && (!oValid || iReady).
- Priority each edge: (1) iBranchTaken: PC<=iBranchTarget, oValid<=0 (flush, in-flight instruction discarded even if iReady=1; it does count in oFetchCount if accepted that cycle). (2) else Load: capture iInstruction fields, oPC<=PC, PC<=PC+1, oValid<=1. (3) else if Accept: oValid<=0. (4) else hold all.
- Stall: oValid=1 && iReady=0 -> outputs and PC frozen; iInstruction ignored.
- PC arithmetic: 16-bit unsigned, 16'hFFFF+1 wraps to 16'h0000, no flag.
- iEnable=0: presented instruction stays until accepted, then oValid drops; PC frozen; branch still honoured.
- Decoding is field extraction only; no opcode legality check (unknown opcodes passed through).

## Timing
- oAddress combinational from PC; ROM path is a single-cycle combinational read.
- Latency: instruction at PC visible on outputs one edge after Load.
- Throughput: 1 instruction/cycle while iEnable=1 and iReady=1.
- Branch penalty: branch edge -> oValid=0 for one cycle -> target instruction valid on the following edge.
- First instruction after Reset release: valid after first rising edge with iEnable=1.
- Reset asserted mid-stall or mid-branch: all state returns to reset values immediately (async), no pending redirect survives.

## Test plan
- ROM {0: NOP 24'd4000, 1: STO R1 16'd7, 2: STO R2 16'd5, 3: IMUL R3 R1 R2}, iReady=1 -> oPC 0,1,2,3 on consecutive cycles; cycle 2 oImm=7; cycle 4 oOpcode=IMUL, oSrc1=R1, oSrc0=R2; oFetchCount=4 after.
- iReady=0 for 3 cycles while IMUL presented -> outputs, oAddress=4, oFetchCount frozen; release -> address 4 (LED default) next cycle.
- iBranchTaken with target 16'd1 while oPC=2 presented -> next cycle oValid=0; following cycle oPC=1, oImm=7.
- Branch to 16'hFFFF -> oPC FFFF then 0000, no stall.
- iEnable=0 with oValid=1, iReady=1 -> one accept, then oValid=0 and oAddress constant until iEnable=1.
- Reset asserted asynchronously mid-stream -> oValid=0, oAddress=RESET_PC, oFetchCount=0 before next edge.

Source files
------------

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-unit port bundle: ROM address/data plus the valid/ready link to execute.
// master = fetch unit, slave = ROM/execute environment.
interface instruction_fetch_unit_if #(
    parameter int ADDR_WIDTH = 16,
    parameter int OP_WIDTH   = 4,
    parameter int REG_WIDTH  = 8
);
    localparam int INSTR_WIDTH = OP_WIDTH + 3 * REG_WIDTH;

    // ROM side
    logic [ADDR_WIDTH-1:0]  oAddress;
    logic [INSTR_WIDTH-1:0] iInstruction;

    // Control from execute
    logic                   iEnable;
    logic                   iBranchTaken;
    logic [ADDR_WIDTH-1:0]  iBranchTarget;

    // Decoded instruction towards execute
    logic                   oValid;
    logic                   iReady;
    logic [OP_WIDTH-1:0]    oOpcode;
    logic [REG_WIDTH-1:0]   oDest;
    logic [REG_WIDTH-1:0]   oSrc1;
    logic [REG_WIDTH-1:0]   oSrc0;
    logic [2*REG_WIDTH-1:0] oImm;
    logic [ADDR_WIDTH-1:0]  oPC;
    logic [15:0]            oFetchCount;

    modport master (
        output oAddress,
        input  iInstruction,
        input  iEnable,
        input  iBranchTaken,
        input  iBranchTarget,
        output oValid,
        input  iReady,
        output oOpcode,
        output oDest,
        output oSrc1,
        output oSrc0,
        output oImm,
        output oPC,
        output oFetchCount
    );

    modport slave (
        input  oAddress,
        output iInstruction,
        output iEnable,
        output iBranchTaken,
        output iBranchTarget,
        input  oValid,
        output iReady,
        input  oOpcode,
        input  oDest,
        input  oSrc1,
        input  oSrc0,
        input  oImm,
        input  oPC,
        input  oFetchCount
    );
endinterface

// File: rtl/instruction_fetch_unit.sv
// Fetch/decode stage: instruction at PC appears one edge after load, one per cycle.
// Holds outputs and PC while oValid && !iReady; a taken branch flushes with a one-cycle bubble.
module instruction_fetch_unit #(
    parameter logic [15:0] RESET_PC  = 16'd0,
    parameter int          OP_WIDTH  = 4,
    parameter int          REG_WIDTH = 8
) (
    input  logic                      Clock,
    input  logic                      Reset,
    instruction_fetch_unit_if.master  bus
);
    localparam int INSTR_WIDTH = OP_WIDTH + 3 * REG_WIDTH;

    logic [15:0]            pc_q,      pc_d;
    logic                   valid_q,   valid_d;
    logic [OP_WIDTH-1:0]    opcode_q,  opcode_d;
    logic [REG_WIDTH-1:0]   dest_q,    dest_d;
    logic [REG_WIDTH-1:0]   src1_q,    src1_d;
    logic [REG_WIDTH-1:0]   src0_q,    src0_d;
    logic [2*REG_WIDTH-1:0] imm_q,     imm_d;
    logic [15:0]            out_pc_q,  out_pc_d;
    logic [15:0]            count_q,   count_d;

    logic [INSTR_WIDTH-1:0] instr;
    logic                   accept;
    logic                   load;

    assign instr  = bus.iInstruction;
    assign accept = valid_q && bus.iReady;
    assign load   = bus.iEnable && (!valid_q || bus.iReady);

    always_comb begin
        pc_d     = pc_q;
        valid_d  = valid_q;
        opcode_d = opcode_q;
        dest_d   = dest_q;
        src1_d   = src1_q;
        src0_d   = src0_q;
        imm_d    = imm_q;
        out_pc_d = out_pc_q;
        // An instruction accepted in the branch cycle still counts even though it is flushed.
        count_d  = accept ? count_q + 16'd1 : count_q;

        if (bus.iBranchTaken) begin
            pc_d    = bus.iBranchTarget;
            valid_d = 1'b0;
        end else if (load) begin
            opcode_d = instr[INSTR_WIDTH-1 -: OP_WIDTH];
            dest_d   = instr[3*REG_WIDTH-1 -: REG_WIDTH];
            src1_d   = instr[2*REG_WIDTH-1 -: REG_WIDTH];
            src0_d   = instr[REG_WIDTH-1:0];
            imm_d    = instr[2*REG_WIDTH-1:0];
            out_pc_d = pc_q;
            pc_d     = pc_q + 16'd1;
            valid_d  = 1'b1;
        end else if (accept) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            pc_q     <= RESET_PC;
            valid_q  <= 1'b0;
            opcode_q <= '0;
            dest_q   <= '0;
            src1_q   <= '0;
            src0_q   <= '0;
            imm_q    <= '0;
            out_pc_q <= '0;
            count_q  <= '0;
        end else begin
            pc_q     <= pc_d;
            valid_q  <= valid_d;
            opcode_q <= opcode_d;
            dest_q   <= dest_d;
            src1_q   <= src1_d;
            src0_q   <= src0_d;
            imm_q    <= imm_d;
            out_pc_q <= out_pc_d;
            count_q  <= count_d;
        end
    end

    assign bus.oAddress    = pc_q;
    assign bus.oValid      = valid_q;
    assign bus.oOpcode     = opcode_q;
    assign bus.oDest       = dest_q;
    assign bus.oSrc1       = src1_q;
    assign bus.oSrc0       = src0_q;
    assign bus.oImm        = imm_q;
    assign bus.oPC         = out_pc_q;
    assign bus.oFetchCount = count_q;
endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit with a small combinational ROM model.
module tb_instruction_fetch_unit;
    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_STO  = 4'h1;
    localparam logic [3:0] OP_IMUL = 4'h5;
    localparam logic [3:0] OP_LED  = 4'hE;

    logic Clock = 1'b0;
    logic Reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    instruction_fetch_unit_if #(.ADDR_WIDTH(16), .OP_WIDTH(4), .REG_WIDTH(8)) bus ();

    instruction_fetch_unit #(.RESET_PC(16'd0), .OP_WIDTH(4), .REG_WIDTH(8)) dut (
        .Clock (Clock),
        .Reset (Reset),
        .bus   (bus.master)
    );

    always #5 Clock = ~Clock;

    // Unprogrammed addresses return an LED instruction whose payload is the address itself.
    function automatic logic [27:0] rom(input logic [15:0] a);
        case (a)
            16'd0:   rom = {OP_NOP, 24'd4000};
            16'd1:   rom = {OP_STO, 8'd1, 16'd7};
            16'd2:   rom = {OP_STO, 8'd2, 16'd5};
            16'd3:   rom = {OP_IMUL, 8'd3, 8'd1, 8'd2};
            default: rom = {OP_LED, 8'hA5, a};
        endcase
    endfunction

    always_comb bus.iInstruction = rom(bus.oAddress);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge Clock);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic v, input logic [15:0] pc,
                           input logic [15:0] addr, input logic [15:0] cnt);
        chk({tag, ".valid"}, 32'(bus.oValid), 32'(v));
        if (v) chk({tag, ".pc"}, 32'(bus.oPC), 32'(pc));
        chk({tag, ".addr"}, 32'(bus.oAddress), 32'(addr));
        chk({tag, ".cnt"}, 32'(bus.oFetchCount), 32'(cnt));
    endtask

    initial begin
        bus.iEnable       = 1'b0;
        bus.iReady        = 1'b0;
        bus.iBranchTaken  = 1'b0;
        bus.iBranchTarget = 16'd0;
        step();
        step();

        chk("rst.valid", 32'(bus.oValid), 32'd0);
        chk("rst.addr", 32'(bus.oAddress), 32'd0);
        chk("rst.cnt", 32'(bus.oFetchCount), 32'd0);
        chk("rst.op", 32'(bus.oOpcode), 32'd0);
        chk("rst.pc", 32'(bus.oPC), 32'd0);
        chk("rst.imm", 32'(bus.oImm), 32'd0);

        Reset = 1'b0;
        bus.iEnable = 1'b1;
        bus.iReady  = 1'b1;

        // Straight-line fetch of addresses 0..3
        step();
        chk_out("f0", 1'b1, 16'd0, 16'd1, 16'd0);
        chk("f0.op", 32'(bus.oOpcode), 32'(OP_NOP));
        chk("f0.imm", 32'(bus.oImm), 32'd4000);
        step();
        chk_out("f1", 1'b1, 16'd1, 16'd2, 16'd1);
        chk("f1.imm", 32'(bus.oImm), 32'd7);
        chk("f1.dest", 32'(bus.oDest), 32'd1);
        chk("f1.op", 32'(bus.oOpcode), 32'(OP_STO));
        step();
        chk_out("f2", 1'b1, 16'd2, 16'd3, 16'd2);
        chk("f2.imm", 32'(bus.oImm), 32'd5);
        step();
        chk_out("f3", 1'b1, 16'd3, 16'd4, 16'd3);
        chk("f3.op", 32'(bus.oOpcode), 32'(OP_IMUL));
        chk("f3.dest", 32'(bus.oDest), 32'd3);
        chk("f3.src1", 32'(bus.oSrc1), 32'd1);
        chk("f3.src0", 32'(bus.oSrc0), 32'd2);

        // Back-pressure: IMUL held for three cycles
        bus.iReady = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk_out("stall", 1'b1, 16'd3, 16'd4, 16'd3);
            chk("stall.op", 32'(bus.oOpcode), 32'(OP_IMUL));
            chk("stall.src0", 32'(bus.oSrc0), 32'd2);
        end
        bus.iReady = 1'b1;
        step();
        chk_out("rel", 1'b1, 16'd4, 16'd5, 16'd4);
        chk("rel.op", 32'(bus.oOpcode), 32'(OP_LED));
        chk("rel.imm", 32'(bus.oImm), 32'd4);
        step();
        chk_out("f5", 1'b1, 16'd5, 16'd6, 16'd5);

        // Branch to 2 while oPC=5 is accepted: it counts but is flushed
        bus.iBranchTaken  = 1'b1;
        bus.iBranchTarget = 16'd2;
        step();
        bus.iBranchTaken = 1'b0;
        chk_out("br2.bub", 1'b0, 16'd0, 16'd2, 16'd6);
        step();
        chk_out("br2.tgt", 1'b1, 16'd2, 16'd3, 16'd6);

        // Branch to 1 while oPC=2 is presented
        bus.iBranchTaken  = 1'b1;
        bus.iBranchTarget = 16'd1;
        step();
        bus.iBranchTaken = 1'b0;
        chk_out("br1.bub", 1'b0, 16'd0, 16'd1, 16'd7);
        step();
        chk_out("br1.tgt", 1'b1, 16'd1, 16'd2, 16'd7);
        chk("br1.imm", 32'(bus.oImm), 32'd7);

        // Branch to the top of the address space: PC wraps with no stall
        bus.iBranchTaken  = 1'b1;
        bus.iBranchTarget = 16'hFFFF;
        step();
        bus.iBranchTaken = 1'b0;
        chk_out("brF.bub", 1'b0, 16'd0, 16'hFFFF, 16'd8);
        step();
        chk_out("wrapF", 1'b1, 16'hFFFF, 16'h0000, 16'd8);
        chk("wrapF.imm", 32'(bus.oImm), 32'hFFFF);
        step();
        chk_out("wrap0", 1'b1, 16'h0000, 16'h0001, 16'd9);
        chk("wrap0.op", 32'(bus.oOpcode), 32'(OP_NOP));

        // Fetch disabled: one accept, then idle with PC frozen
        bus.iEnable = 1'b0;
        step();
        chk_out("dis0", 1'b0, 16'd0, 16'd1, 16'd10);
        step();
        chk_out("dis1", 1'b0, 16'd0, 16'd1, 16'd10);
        bus.iEnable = 1'b1;
        step();
        chk_out("ena", 1'b1, 16'd1, 16'd2, 16'd10);

        // Asynchronous reset in mid-cycle, with a branch pending
        bus.iBranchTaken  = 1'b1;
        bus.iBranchTarget = 16'h0040;
        #3;
        Reset = 1'b1;
        #1;
        chk("arst.valid", 32'(bus.oValid), 32'd0);
        chk("arst.addr", 32'(bus.oAddress), 32'd0);
        chk("arst.cnt", 32'(bus.oFetchCount), 32'd0);
        chk("arst.pc", 32'(bus.oPC), 32'd0);
        step();
        bus.iBranchTaken = 1'b0;
        Reset = 1'b0;
        step();
        chk_out("post", 1'b1, 16'd0, 16'd1, 16'd0);
        chk("post.imm", 32'(bus.oImm), 32'd4000);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
